// File: rtl/cipher_cfg_pkg.sv
// -----------------------------------------------------------------------------
// cipher_cfg_pkg
//
// Purpose:
//   Types and sizing helpers shared by the configuration loader
//   (cipher_cfg_loader, cfg_piso) and by cipher test benches.
//
// Contents:
//   state_t    loader FSM states {COLLECT, SHIFT, DONE, READBACK}
//   cfg_w(m)   configuration vector length in bits for LFSR width m (4*m+2)
//   nbytes(m)  bytes needed to carry one configuration vector
//
// Optional feature macro used by the files importing this package:
//   CFG_READBACK_EN
// -----------------------------------------------------------------------------
package cipher_cfg_pkg;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    SHIFT    = 2'd1,
    DONE     = 2'd2,
    READBACK = 2'd3
  } state_t;

  function automatic int cfg_w(input int m);
    return 4 * m + 2;
  endfunction

  function automatic int nbytes(input int m);
    return (cfg_w(m) + 7) / 8;
  endfunction

endpackage

// File: rtl/cfg_piso.sv
// -----------------------------------------------------------------------------
// cfg_piso
//
// Purpose:
//   W-bit parallel-load shift register holding the configuration vector.
//   Shifts right (towards bit 0) so the vector leaves LSB-first on o_ser.
//   With CFG_READBACK_EN defined, i_ser_in enters at the MSB on each shift,
//   which lets the same register capture the cipher's outgoing vector while
//   the new one is being shifted out.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset, clears the register
//   i_load       in   parallel load of i_load_data (wins over i_shift)
//   i_load_data  in   W-bit parallel load value
//   i_shift      in   shift right by one bit
//   i_ser_in     in   serial input at MSB (only with CFG_READBACK_EN)
//   o_par        out  current register contents
//   o_ser        out  bit 0 of the register
//
// Configuration macro: CFG_READBACK_EN
// -----------------------------------------------------------------------------
module cfg_piso
  import cipher_cfg_pkg::*;
#(
  parameter int W = 130
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_data,
  input  logic         i_shift,
`ifdef CFG_READBACK_EN
  input  logic         i_ser_in,
`endif
  output logic [W-1:0] o_par,
  output logic         o_ser
);

  logic [W-1:0] r_sreg;
  logic         w_ser_in;

`ifdef CFG_READBACK_EN
  assign w_ser_in = i_ser_in;
`else
  assign w_ser_in = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg <= '0;
    end else if (i_load) begin
      r_sreg <= i_load_data;
    end else if (i_shift) begin
      r_sreg <= {w_ser_in, r_sreg[W-1:1]};
    end
  end

  assign o_par = r_sreg;
  assign o_ser = r_sreg[0];

endmodule

// File: rtl/cipher_cfg_loader.sv
// -----------------------------------------------------------------------------
// cipher_cfg_loader
//
// Purpose:
//   Collects a full cipher configuration vector (CFG_W bits) as a byte stream,
//   then drives cfg_en/cfg_i to the cipher for exactly CFG_W consecutive
//   cycles, LSB first. The cipher only commits a configuration after an
//   unbroken cfg_en run of that length, so once SHIFT starts nothing except
//   rst can stop it.
//
// Handshake (in_* and rb_*): a transfer happens on a rising clk edge where
//   valid && ready are both high. The source keeps valid and data stable
//   until the transfer; ready here depends only on the FSM state, never on
//   valid, so there is no combinational loop.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   in_valid   in   configuration byte valid
//   in_ready   out  high in COLLECT
//   in_data    in   byte k carries cfg[8k+7:8k]; bits above CFG_W-1 dropped
//   cfg_en     out  registered, high for CFG_W cycles in SHIFT
//   cfg_i      out  registered serial configuration bit
//   cfg_o      in   cipher serial output (captured only with CFG_READBACK_EN)
//   busy       out  high in SHIFT
//   done       out  one-cycle pulse after the last shift cycle
//   rb_valid   out  readback byte valid       (CFG_READBACK_EN only)
//   rb_ready   in   readback byte accepted    (CFG_READBACK_EN only)
//   rb_data    out  readback byte k = previous cfg[8k+7:8k], zero padded
//   dbg_state  out  current FSM state (state_t encoding)
//
// Configuration macro: CFG_READBACK_EN
// -----------------------------------------------------------------------------
module cipher_cfg_loader
  import cipher_cfg_pkg::*;
#(
  parameter int M = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       cfg_en,
  output logic       cfg_i,
  input  logic       cfg_o,
  output logic       busy,
  output logic       done,
`ifdef CFG_READBACK_EN
  output logic       rb_valid,
  input  logic       rb_ready,
  output logic [7:0] rb_data,
`endif
  output logic [1:0] dbg_state
);

  localparam int CFG_W  = cfg_w(M);
  localparam int NBYTES = nbytes(M);
  localparam int BIT_W  = $clog2(CFG_W + 1);
  localparam int BYTE_W = $clog2(NBYTES + 1);

  state_t              r_state;
  state_t              w_next;
  logic [BYTE_W-1:0]   r_byte_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic                r_cfg_en;
  logic                r_cfg_i;

  logic [CFG_W-1:0]    w_par;
  logic [CFG_W-1:0]    w_load_data;
  logic                w_ser;
  logic                w_accept;
  logic                w_shift;
  logic                w_last_byte;
  logic                w_last_bit;
  logic                w_unused;

  assign w_accept    = (r_state == COLLECT) && in_valid;
  assign w_shift     = (r_state == SHIFT);
  assign w_last_byte = (r_byte_cnt == BYTE_W'(NBYTES - 1));
  assign w_last_bit  = (r_bit_cnt == BIT_W'(CFG_W - 1));

  // Byte merge: the incoming byte replaces its slot of the held vector and
  // every other bit keeps its value. Slots above CFG_W-1 simply do not exist,
  // which is how the top bits of the last byte are dropped.
  for (genvar gi = 0; gi < CFG_W; gi++) begin : g_merge
    assign w_load_data[gi] = (r_byte_cnt == BYTE_W'(gi / 8)) ? in_data[gi % 8]
                                                              : w_par[gi];
  end

  cfg_piso #(
    .W (CFG_W)
  ) u_piso (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_load_data (w_load_data),
    .i_shift     (w_shift),
`ifdef CFG_READBACK_EN
    .i_ser_in    (cfg_o),
`endif
    .o_par       (w_par),
    .o_ser       (w_ser)
  );

  // cfg_i is pre-fetched one bit ahead: while bit j is on the wire, the
  // register still has bit j at position 0, so bit j+1 sits at position 1.
  // Both bits move into r_cfg_i together with the shift on the same edge.
`ifdef CFG_READBACK_EN
  assign w_unused = w_ser;
`else
  assign w_unused = w_ser ^ cfg_o;
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      COLLECT: begin
        if (in_valid && w_last_byte) begin
          w_next = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last_bit) begin
          w_next = DONE;
        end
      end
      DONE: begin
`ifdef CFG_READBACK_EN
        w_next = READBACK;
`else
        w_next = COLLECT;
`endif
      end
      READBACK: begin
`ifdef CFG_READBACK_EN
        if (rb_ready && w_last_byte) begin
          w_next = COLLECT;
        end
`else
        w_next = COLLECT;
`endif
      end
      default: begin
        w_next = COLLECT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters and registered cipher drive
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt <= '0;
      r_bit_cnt  <= '0;
      r_cfg_en   <= 1'b0;
      r_cfg_i    <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (in_valid) begin
            if (w_last_byte) begin
              // First shift bit comes from the merged value, since the last
              // byte is only now being written into the register.
              r_byte_cnt <= '0;
              r_cfg_en   <= 1'b1;
              r_cfg_i    <= w_load_data[0];
            end else begin
              r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
            end
          end
        end
        SHIFT: begin
          if (w_last_bit) begin
            r_bit_cnt <= '0;
            r_cfg_en  <= 1'b0;
            r_cfg_i   <= 1'b0;
          end else begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            r_cfg_i   <= w_par[1];
          end
        end
        DONE: begin
          r_byte_cnt <= '0;
          r_bit_cnt  <= '0;
        end
        READBACK: begin
`ifdef CFG_READBACK_EN
          if (rb_ready) begin
            if (w_last_byte) begin
              r_byte_cnt <= '0;
            end else begin
              r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
            end
          end
`endif
        end
        default: begin
          r_byte_cnt <= '0;
          r_bit_cnt  <= '0;
        end
      endcase
    end
  end

`ifdef CFG_READBACK_EN
  // ---------------------------------------------------------------------------
  // Readback: after SHIFT the register holds the captured cfg_o stream, which
  // is the cipher's previous configuration in its original bit order.
  // ---------------------------------------------------------------------------
  logic [NBYTES*8-1:0] w_rb_pad;

  assign w_rb_pad = (NBYTES * 8)'(w_par);
  assign rb_valid = (r_state == READBACK);

  always_comb begin
    rb_data = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (r_byte_cnt == BYTE_W'(k)) begin
        rb_data = w_rb_pad[k*8 +: 8];
      end
    end
  end
`endif

  assign in_ready  = (r_state == COLLECT);
  assign busy      = (r_state == SHIFT);
  assign done      = (r_state == DONE);
  assign cfg_en    = r_cfg_en;
  assign cfg_i     = r_cfg_i;
  assign dbg_state = r_state;

endmodule
